kbd_mmio_fifo: RTL

//   Keyboard-input stage directly upstream of the rv32 CPU data port.

---
 rtl/kbd_mmio_fifo.sv | 88 ++++++++
 1 files changed

// File: rtl/kbd_mmio_fifo.sv
// kbd_mmio_fifo: keyboard byte FIFO exposed to the CPU as memory-mapped DATA/STATUS registers
module kbd_mmio_fifo #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0030_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PONE = 1;
    localparam logic [CW-1:0] CONE = 1;
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic          is_data, is_stat, empty, full, pop, push, drop, clr;
    logic [7:0]    head;

    assign is_data = addr == BASE_ADDR;
    assign is_stat = addr == BASE_ADDR + 32'd4;
    assign hit     = is_data || is_stat;
    assign rdata   = rdata_q;
    assign irq     = irq_q;

    // Queue bookkeeping, register reads and sticky overflow/drop tracking for the next edge
    always_comb begin
        empty      = count_q == '0;
        full       = count_q == CFULL;
        head       = empty ? 8'h00 : mem_q[rd_ptr_q];
        pop        = rd_en && is_data && !empty;
        push       = key_valid && (!full || pop);
        drop       = key_valid && full && !pop;
        clr        = wr_en && is_stat && wdata[0];
        wr_ptr_d   = push ? wr_ptr_q + PONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PONE : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + CONE :
                     (pop && !push) ? count_q - CONE : count_q;
        overflow_d = drop ? 1'b1 : clr ? 1'b0 : overflow_q;
        drop_cnt_d = drop ? (clr ? 8'd1 : (drop_cnt_q == 8'hFF ? 8'hFF : drop_cnt_q + 8'd1)) :
                     clr ? 8'd0 : drop_cnt_q;
        rdata_d    = !rd_en ? rdata_q :
                     is_data ? {24'b0, head} :
                     is_stat ? {8'b0, drop_cnt_q, 8'(count_q), 5'b0, overflow_q, full, empty} :
                     32'b0;
        irq_d      = count_d != '0;
    end

    // Byte storage; stale entries are harmless because pointers define validity
    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_ptr_q] <= key_code;
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
            rdata_q    <= 32'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end
endmodule
